// File: rtl/program_counter_stack.sv
// SAP program counter with jump, zero-conditional jump and CALL/RET over a
// small hardware return-address stack; drives the shared bus through a tri-state port.
module program_counter_stack #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                       CLOCK,
    input  logic                       _RESET,
    input  logic [WIDTH-1:0]           PC_IN,
    input  logic                       PC_INC,
    input  logic                       _JMP,
    input  logic                       _JZ,
    input  logic                       ZERO,
    input  logic                       _CALL,
    input  logic                       _RET,
    input  logic                       _EN_PC_OUT,
    output logic [WIDTH-1:0]           PC_OUT,
    output logic [WIDTH-1:0]           PC_VALUE,
    output logic [$clog2(DEPTH+1)-1:0] STACK_LEVEL,
    output logic                       STACK_OVF,
    output logic                       STACK_UNF
);

    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] count_reg, count_next;
    logic [LW-1:0]    sp_reg, sp_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             push;
    logic [WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0] stk_top;
    logic [DEPTH-1:0] wr_en;
    logic [WIDTH-1:0] stk_reg [DEPTH];

    // The return address wraps naturally, so a CALL at all-ones pushes zero.
    assign ret_addr = count_reg + WIDTH'(1);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr
            assign wr_en[gi] = push && (sp_reg == LW'(gi));
        end
    endgenerate

    // Top-of-stack select without an out-of-range index when SP is zero.
    always_comb begin
        stk_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_reg == LW'(i + 1)) begin
                stk_top = stk_reg[i];
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        sp_next    = sp_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        push       = 1'b0;
        if (!_JMP) begin
            count_next = PC_IN;
        end else if (!_JZ && ZERO) begin
            count_next = PC_IN;
        end else if (!_CALL) begin
            if (sp_reg != LW'(DEPTH)) begin
                push       = 1'b1;
                sp_next    = sp_reg + LW'(1);
                count_next = PC_IN;
            end else begin
                ovf_next = 1'b1;
            end
        end else if (!_RET) begin
            if (sp_reg != '0) begin
                count_next = stk_top;
                sp_next    = sp_reg - LW'(1);
            end else begin
                unf_next = 1'b1;
            end
        end else if (PC_INC) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!_RESET) begin
            count_reg <= RESET_VECTOR;
            sp_reg    <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            sp_reg    <= sp_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Entries above SP are left alone on a pop; only reset clears them.
    always_ff @(posedge CLOCK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!_RESET) begin
                stk_reg[i] <= '0;
            end else if (wr_en[i]) begin
                stk_reg[i] <= ret_addr;
            end
        end
    end

    assign PC_OUT      = _EN_PC_OUT ? {WIDTH{1'bz}} : count_reg;
    assign PC_VALUE    = count_reg;
    assign STACK_LEVEL = sp_reg;
    assign STACK_OVF   = ovf_reg;
    assign STACK_UNF   = unf_reg;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed vector table plus randomized run against a queue-based reference
// model of the program counter and its return stack.
module tb_program_counter_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam logic [7:0] RV = 8'h10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pc_in = '0;
    logic       inc = 1'b0;
    logic       jmp_n = 1'b1;
    logic       jz_n = 1'b1;
    logic       zero = 1'b0;
    logic       call_n = 1'b1;
    logic       ret_n = 1'b1;
    logic       en_n = 1'b0;
    wire  [7:0] pc_out;
    logic [7:0] pc_value;
    logic [2:0] stack_level;
    logic       stack_ovf;
    logic       stack_unf;

    // Weak pull-ups make an undriven bus read as all ones.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pu
        pullup (pc_out[i]);
    end

    program_counter_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .CLOCK(clk), ._RESET(rst_n), .PC_IN(pc_in), .PC_INC(inc), ._JMP(jmp_n),
        ._JZ(jz_n), .ZERO(zero), ._CALL(call_n), ._RET(ret_n), ._EN_PC_OUT(en_n),
        .PC_OUT(pc_out), .PC_VALUE(pc_value), .STACK_LEVEL(stack_level),
        .STACK_OVF(stack_ovf), .STACK_UNF(stack_unf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: counter plus a queue used as a bounded LIFO.
    logic [7:0] m_count;
    logic [7:0] m_stk[$];
    logic       m_ovf, m_unf;

    task automatic model_step();
        if (!rst_n) begin
            m_count = RV;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!jmp_n) begin
            m_count = pc_in;
        end else if (!jz_n && zero) begin
            m_count = pc_in;
        end else if (!call_n) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(m_count + 8'd1);
                m_count = pc_in;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (!ret_n) begin
            if (m_stk.size() > 0) m_count = m_stk.pop_back();
            else m_unf = 1'b1;
        end else if (inc) begin
            m_count = m_count + 8'd1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input logic [7:0] e_pc, input logic [2:0] e_lvl,
                             input logic e_ovf, input logic e_unf);
        chk("pc_value", {24'd0, pc_value}, {24'd0, e_pc});
        chk("stack_level", {29'd0, stack_level}, {29'd0, e_lvl});
        chk("stack_ovf", {31'd0, stack_ovf}, {31'd0, e_ovf});
        chk("stack_unf", {31'd0, stack_unf}, {31'd0, e_unf});
        if (en_n) begin
            if (e_pc != 8'hFF) chk("pc_out_z", {24'd0, pc_out}, 32'hFF);
        end else begin
            chk("pc_out", {24'd0, pc_out}, {24'd0, e_pc});
        end
    endtask

    typedef struct {
        string      op;
        logic       zero;
        logic [7:0] pc_in;
        logic [7:0] exp_pc;
        logic [2:0] exp_lvl;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    function automatic vec_t mk(input string op, input logic z, input logic [7:0] pi,
                                input logic [7:0] epc, input logic [2:0] el,
                                input logic eo, input logic eu);
        vec_t v;
        v.op = op; v.zero = z; v.pc_in = pi;
        v.exp_pc = epc; v.exp_lvl = el; v.exp_ovf = eo; v.exp_unf = eu;
        return v;
    endfunction

    task automatic drive_op(input string op, input logic z, input logic [7:0] pi);
        rst_n = 1'b1; jmp_n = 1'b1; jz_n = 1'b1; call_n = 1'b1; ret_n = 1'b1;
        inc = 1'b0; en_n = 1'b0; zero = z; pc_in = pi;
        case (op)
            "RST":  rst_n = 1'b0;
            "JMP":  jmp_n = 1'b0;
            "JZ":   begin jz_n = 1'b0; inc = 1'b1; end
            "CALL": call_n = 1'b0;
            "RET":  ret_n = 1'b0;
            "INC":  inc = 1'b1;
            "COLL": begin jmp_n = 1'b0; call_n = 1'b0; inc = 1'b1; end
            "OFF":  en_n = 1'b1;
            default: ;
        endcase
    endtask

    // Drives one cycle; inputs change 1 time unit after the edge, outputs sampled there.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(mk("RST",  0, 8'h00, 8'h10, 0, 0, 0));
        tbl.push_back(mk("IDLE", 0, 8'h00, 8'h10, 0, 0, 0));
        tbl.push_back(mk("JMP",  0, 8'h20, 8'h20, 0, 0, 0));
        tbl.push_back(mk("COLL", 0, 8'h55, 8'h55, 0, 0, 0));
        tbl.push_back(mk("IDLE", 0, 8'h00, 8'h55, 0, 0, 0));
        tbl.push_back(mk("JMP",  0, 8'h30, 8'h30, 0, 0, 0));
        tbl.push_back(mk("JZ",   0, 8'h55, 8'h31, 0, 0, 0));
        tbl.push_back(mk("JMP",  0, 8'h30, 8'h30, 0, 0, 0));
        tbl.push_back(mk("JZ",   1, 8'h55, 8'h55, 0, 0, 0));
        tbl.push_back(mk("JMP",  0, 8'h02, 8'h02, 0, 0, 0));
        tbl.push_back(mk("CALL", 0, 8'h40, 8'h40, 1, 0, 0));
        tbl.push_back(mk("CALL", 0, 8'h80, 8'h80, 2, 0, 0));
        tbl.push_back(mk("RET",  0, 8'h00, 8'h41, 1, 0, 0));
        tbl.push_back(mk("RET",  0, 8'h00, 8'h03, 0, 0, 0));
        tbl.push_back(mk("CALL", 0, 8'h90, 8'h90, 1, 0, 0));
        tbl.push_back(mk("CALL", 0, 8'hA0, 8'hA0, 2, 0, 0));
        tbl.push_back(mk("CALL", 0, 8'hB0, 8'hB0, 3, 0, 0));
        tbl.push_back(mk("CALL", 0, 8'hC0, 8'hC0, 4, 0, 0));
        tbl.push_back(mk("CALL", 0, 8'hD0, 8'hC0, 4, 1, 0));
        tbl.push_back(mk("RET",  0, 8'h00, 8'hB1, 3, 1, 0));
        tbl.push_back(mk("RET",  0, 8'h00, 8'hA1, 2, 1, 0));
        tbl.push_back(mk("RET",  0, 8'h00, 8'h91, 1, 1, 0));
        tbl.push_back(mk("RET",  0, 8'h00, 8'h04, 0, 1, 0));
        tbl.push_back(mk("RET",  0, 8'h00, 8'h04, 0, 1, 1));
        tbl.push_back(mk("INC",  0, 8'h00, 8'h05, 0, 1, 1));
        tbl.push_back(mk("OFF",  0, 8'h00, 8'h05, 0, 1, 1));
        tbl.push_back(mk("JMP",  0, 8'hFF, 8'hFF, 0, 1, 1));
        tbl.push_back(mk("CALL", 0, 8'h60, 8'h60, 1, 1, 1));
        tbl.push_back(mk("RET",  0, 8'h00, 8'h00, 0, 1, 1));
        tbl.push_back(mk("CALL", 0, 8'h70, 8'h70, 1, 1, 1));
        tbl.push_back(mk("CALL", 0, 8'h71, 8'h71, 2, 1, 1));
        tbl.push_back(mk("RST",  0, 8'h00, 8'h10, 0, 0, 0));
        tbl.push_back(mk("RET",  0, 8'h00, 8'h10, 0, 0, 1));
        tbl.push_back(mk("RST",  0, 8'h00, 8'h10, 0, 0, 0));

        #1;
        foreach (tbl[k]) begin
            drive_op(tbl[k].op, tbl[k].zero, tbl[k].pc_in);
            cycle();
            $display("vec %0d %s pc_in=%0h -> pc=%0h lvl=%0d ovf=%0b unf=%0b",
                     k, tbl[k].op, tbl[k].pc_in, pc_value, stack_level, stack_ovf, stack_unf);
            check_all(tbl[k].exp_pc, tbl[k].exp_lvl, tbl[k].exp_ovf, tbl[k].exp_unf);
        end

        // Increment from the reset vector through the 0xFF -> 0x00 wrap.
        drive_op("INC", 0, 8'h00);
        for (int n = 0; n < 240; n++) cycle();
        $display("inc x240 -> pc=%0h", pc_value);
        check_all(8'h00, 0, 0, 0);

        // Bus enable is combinational: no clock edge between toggles.
        drive_op("JMP", 0, 8'h3C);
        cycle();
        drive_op("OFF", 0, 8'h00);
        #1;
        $display("en off -> pc_out=%0h pc=%0h", pc_out, pc_value);
        chk("pc_out_off", {24'd0, pc_out}, 32'hFF);
        chk("pc_value_off", {24'd0, pc_value}, 32'h3C);
        en_n = 1'b0;
        #1;
        $display("en on -> pc_out=%0h", pc_out);
        chk("pc_out_on", {24'd0, pc_out}, 32'h3C);

        // Randomized run against the reference model.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            rst_n  = ($urandom_range(0, 49) != 0);
            jmp_n  = ($urandom_range(0, 7) != 0);
            jz_n   = ($urandom_range(0, 5) != 0);
            zero   = $urandom_range(0, 1);
            call_n = ($urandom_range(0, 2) != 0);
            ret_n  = ($urandom_range(0, 2) != 0);
            inc    = $urandom_range(0, 1);
            en_n   = $urandom_range(0, 1);
            pc_in  = 8'($urandom);
            cycle();
            $display("rnd %0d pc=%0h lvl=%0d ovf=%0b unf=%0b",
                     n, pc_value, stack_level, stack_ovf, stack_unf);
            check_all(m_count, 3'(m_stk.size()), m_ovf, m_unf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_counter_stack.md
# program_counter_stack

Parametrised program counter for the SAP datapath: a WIDTH-bit counter with increment, unconditional and zero-conditional jump, and subroutine CALL/RET backed by a DEPTH-entry hardware return-address stack. It drives the shared address bus through a tri-state output enabled by an active-low strobe and exposes the stack status as sticky error flags to the control unit.

## Interface
Parameters:
- WIDTH, 8, counter/address width in bits (≥ 2)
- DEPTH, 4, return-stack entries (≥ 1)
- RESET_VECTOR, 0, counter value loaded on reset

Ports:
- CLOCK  in  1  rising-edge clock
- _RESET  in  1  synchronous, active-low reset
- PC_IN  in  WIDTH  jump/call target from the bus
- PC_INC  in  1  active-high increment request
- _JMP  in  1  active-low unconditional jump
- _JZ  in  1  active-low jump-if-zero, qualified by ZERO
- ZERO  in  1  zero flag from the ALU flag register
- _CALL  in  1  active-low call: push return address, load PC_IN
- _RET  in  1  active-low return: pop into the counter
- _EN_PC_OUT  in  1  active-low bus drive enable
- PC_OUT  out  WIDTH  counter onto the bus, all-Z when _EN_PC_OUT high
- PC_VALUE  out  WIDTH  counter, always driven (debug/monitor)
- STACK_LEVEL  out  clog2(DEPTH+1)  number of occupied stack entries
- STACK_OVF  out  1  sticky: a CALL was attempted with the stack full
- STACK_UNF  out  1  sticky: a RET was attempted with the stack empty

## Operation
- State: counter register COUNT, stack array STK[0..DEPTH-1], pointer SP (0..DEPTH), flags OVF/UNF.
- Per-edge action, strict priority, exactly one action per cycle:
  1. _RESET low: COUNT = RESET_VECTOR, SP = 0, all STK = 0, OVF = UNF = 0.
  2. _JMP low: COUNT = PC_IN.
  3. _JZ low and ZERO = 1: COUNT = PC_IN. _JZ low with ZERO = 0 is a no-op for this priority level; evaluation falls through to levels 4-6.
  4. _CALL low: if SP < DEPTH, STK[SP] = COUNT + 1 (mod 2^WIDTH), SP = SP + 1, COUNT = PC_IN. If SP = DEPTH: COUNT, SP, STK unchanged, OVF = 1.
  5. _RET low: if SP > 0, COUNT = STK[SP-1], SP = SP - 1. If SP = 0: COUNT unchanged, UNF = 1.
  6. PC_INC high: COUNT = COUNT + 1, wrapping from 2^WIDTH-1 to 0.
  7. Otherwise hold.
- Lower-priority strobes asserted in the same cycle are ignored and not deferred.
- OVF/UNF are cleared only by reset.
- Stack contents above SP are don't-care after a pop; they are not cleared.
- PC_OUT = COUNT when _EN_PC_OUT = 0, else high-Z. PC_VALUE = COUNT always. STACK_LEVEL = SP, STACK_OVF = OVF, STACK_UNF = UNF.

## Timing
- All state changes on the CLOCK rising edge only; no asynchronous paths into state.
- Reset values, visible the cycle after the reset edge: PC_VALUE = RESET_VECTOR, STACK_LEVEL = 0, flags 0; PC_OUT follows _EN_PC_OUT combinationally, so it is also RESET_VECTOR if enabled.
- Latency:
  - Jump, call, return and increment results appear on PC_VALUE one edge after the strobe is sampled.
  - PC_OUT enable/disable is combinational (zero cycles).
- Back-to-back operations are allowed on consecutive cycles; a RET immediately after a CALL returns to the CALL's COUNT + 1.
- Reset asserted mid-sequence, with the stack non-empty, discards all stack contents on that edge.
- Return address wrap: a CALL at COUNT = 2^WIDTH-1 pushes 0.

## Test plan
- Reset/increment/wrap (WIDTH=8, RESET_VECTOR=0x10):
  - _RESET low one edge -> PC_VALUE = 0x10, STACK_LEVEL = 0.
  - PC_INC high 240 cycles -> PC_VALUE = 0x00 (wrap from 0xFF).
- Priority collision: COUNT = 0x20, PC_IN = 0x55, _JMP, _CALL and PC_INC all asserted -> PC_VALUE = 0x55, STACK_LEVEL unchanged.
- Conditional jump:
  - _JZ low, ZERO = 0, PC_INC high at COUNT = 0x30 -> 0x31.
  - Same cycle with ZERO = 1 -> 0x55.
- Nested call/return (DEPTH=4):
  - CALL at 0x02 -> 0x40, then CALL at 0x40 -> 0x80 -> STACK_LEVEL = 2.
  - RET -> 0x41.
  - RET -> 0x03, STACK_LEVEL = 0.
- Overflow/underflow:
  - Fifth CALL with the stack full -> COUNT holds, STACK_LEVEL = 4, STACK_OVF = 1.
  - Pop to empty, then one extra RET -> COUNT holds, STACK_UNF = 1.
  - Both flags stay at 1 until _RESET low.
- Bus drive: _EN_PC_OUT high -> PC_OUT all Z while PC_VALUE tracks COUNT; _EN_PC_OUT low -> PC_OUT = PC_VALUE in the same cycle.
